// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg : shared types for the accumulate/writeback stage.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package wb_pkg;
  localparam int BLOCK_WORDS = 64;
  localparam int ROW_WORDS   = 8;

  typedef logic signed [31:0]      word_t;
  typedef word_t [BLOCK_WORDS-1:0] block_t;
  typedef word_t [ROW_WORDS-1:0]   row_t;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    FLUSH = 1'b1
  } wb_state_t;
endpackage

`default_nettype wire

// File: rtl/sat_add.sv
// ---------------------------------------------------------------------------
// sat_add : combinational signed adder, optional clamp on overflow.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sat_add #(
  parameter int WORD_W   = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic signed [WORD_W-1:0] a,
  input  logic signed [WORD_W-1:0] b,
  output logic signed [WORD_W-1:0] y
);

  logic signed [WORD_W-1:0] sum;
  logic                     ovf;

  always_comb begin
    sum = a + b;
    // Overflow only when both operands share a sign that the sum does not.
    ovf = (a[WORD_W-1] == b[WORD_W-1]) && (sum[WORD_W-1] != a[WORD_W-1]);
    y   = sum;
    if (SATURATE && ovf) begin
      y = a[WORD_W-1] ? {1'b1, {(WORD_W-1){1'b0}}} : {1'b0, {(WORD_W-1){1'b1}}};
    end
  end

endmodule

`default_nettype wire

// File: rtl/accum_writeback.sv
// ---------------------------------------------------------------------------
// accum_writeback : sums ALU result blocks, then streams rows to DDR.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module accum_writeback
  import wb_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int DIM        = 8,
  parameter int ROW_STRIDE = 32,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic                      iACC_VALID,
  input  logic [DIM*DIM*WORD_W-1:0] iACC_BLOCK,
  input  logic                      iACC_CLEAR,
  input  logic                      iACC_LAST,
  input  logic [31:0]               iBASE_ADDR,
  output logic                      oBUSY,
  output logic                      oWR_VALID,
  output logic [31:0]               oWR_ADDR,
  output logic [DIM*WORD_W-1:0]     oWR_DATA,
  input  logic                      iWR_READY,
  output logic                      oDONE,
  output logic                      oOVERRUN
);

  localparam int              ROW_W    = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(DIM - 1);

  wb_state_t                state;
  wb_state_t                state_nxt;
  logic signed [WORD_W-1:0] acc [DIM][DIM];
  logic signed [WORD_W-1:0] upd [DIM][DIM];
  logic [ROW_W-1:0]         row;
  logic [31:0]              base;
  logic                     done;
  logic                     overrun;
  logic                     take;
  logic                     beat_ok;
  logic                     last_beat;

  assign take      = iACC_VALID && (state == ACCUM);
  assign beat_ok   = (state == FLUSH) && iWR_READY;
  assign last_beat = beat_ok && (row == LAST_ROW);

  generate
    for (genvar r = 0; r < DIM; r++) begin : g_row
      for (genvar c = 0; c < DIM; c++) begin : g_col
        logic signed [WORD_W-1:0] blk_word;
        logic signed [WORD_W-1:0] sum;

        assign blk_word = iACC_BLOCK[(r*DIM + c)*WORD_W +: WORD_W];

        sat_add #(
          .WORD_W   (WORD_W),
          .SATURATE (SATURATE)
        ) u_add (
          .a (acc[r][c]),
          .b (blk_word),
          .y (sum)
        );

        assign upd[r][c] = iACC_CLEAR ? blk_word : sum;
      end
    end
  endgenerate

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          acc[r][c] <= '0;
        end
      end
    end else if (take) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          acc[r][c] <= upd[r][c];
        end
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      row     <= '0;
      base    <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done <= last_beat;
      if (iACC_VALID && (state == FLUSH)) begin
        overrun <= 1'b1;
      end
      if (take && iACC_LAST) begin
        base <= iBASE_ADDR;
        row  <= '0;
      end else if (beat_ok) begin
        row <= row + 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (take && iACC_LAST) state_nxt = FLUSH;
      FLUSH:   if (last_beat)         state_nxt = ACCUM;
      default:                        state_nxt = ACCUM;
    endcase
  end

  // Write port is decoded straight from state so reset drops it without a clock.
  always_comb begin
    oBUSY     = 1'b0;
    oWR_VALID = 1'b0;
    oWR_ADDR  = '0;
    oWR_DATA  = '0;
    if (state == FLUSH) begin
      oBUSY     = 1'b1;
      oWR_VALID = 1'b1;
      oWR_ADDR  = base + 32'(row) * 32'(ROW_STRIDE);
      for (int c = 0; c < DIM; c++) begin
        oWR_DATA[c*WORD_W +: WORD_W] = acc[row][c];
      end
    end
  end

  assign oDONE    = done;
  assign oOVERRUN = overrun;

endmodule

`default_nettype wire

// File: doc/accum_writeback.md
Name: accum_writeback

Overview:
- Downstream of the ALU stage; consumes the 8x8 result block the ALU issues with its one-cycle accumulate strobe.
- Sums successive result blocks into an internal 64-word accumulator. Typical use: convolution partial sums over input channels, or dot-product partials.
- On the last block of a group, streams the accumulator to the DDR3 write port as eight 256-bit row beats, then pulses done.

Parameters:
- WORD_W, 32, width of one pixel/word (signed two's complement)
- DIM, 8, block edge; block holds DIM*DIM words
- ROW_STRIDE, 32, byte address increment between successive row beats
- SATURATE, 1, 1 = saturating signed add; 0 = wrapping add

Ports:
- iCLK  in  1  clock
- iRST  in  1  asynchronous, active-high reset
- iACC_VALID  in  1  one-cycle strobe from ALU: iACC_BLOCK is valid
- iACC_BLOCK  in  DIM*DIM*WORD_W  result block, word k = row k/DIM, col k%DIM
- iACC_CLEAR  in  1  qualifies iACC_VALID: load block instead of adding (first of group)
- iACC_LAST  in  1  qualifies iACC_VALID: after this update, flush the group
- iBASE_ADDR  in  32  destination byte address, sampled when iACC_VALID&iACC_LAST
- oBUSY  out  1  high while flushing; upstream must not strobe
- oWR_VALID  out  1  write beat valid
- oWR_ADDR  out  32  beat byte address
- oWR_DATA  out  DIM*WORD_W  one row, word 0 in LSBs
- iWR_READY  in  1  memory accepts beat when oWR_VALID&iWR_READY
- oDONE  out  1  one-cycle pulse after the final beat is accepted
- oOVERRUN  out  1  sticky: strobe arrived while oBUSY

Behaviour:
- Reset (async assert, sync release): state ACCUM, accumulator all 0, row counter 0, all outputs 0.
- ACCUM state, on iACC_VALID:
  - CLEAR=1: acc[k] <= block[k].
  - CLEAR=0: acc[k] <= acc[k] + block[k].
  - All 64 words update in the same cycle.
- Saturating add (SATURATE=1): on signed overflow the result clamps to 0x7FFFFFFF / 0x80000000. With SATURATE=0 the add wraps.
- VALID with LAST=1 (CLEAR may also be 1): the update completes first. Next cycle the state is FLUSH, oBUSY=1, the row counter is 0, and the base address is latched.
- FLUSH state:
  - Drives oWR_VALID=1, oWR_ADDR = base + row*ROW_STRIDE, oWR_DATA = acc row[row].
  - Beat accepted: row++; address and data change the following cycle.
  - Address and data are held stable while iWR_READY is low.
  - After row DIM-1 is accepted: oWR_VALID=0, oBUSY=0, oDONE=1 for one cycle, state ACCUM.
  - The accumulator contents are retained after the flush. The next group must start with CLEAR.
- Latency: first beat is valid 1 cycle after the LAST strobe. With iWR_READY held high, oDONE fires DIM+1 cycles after the strobe.
- iACC_VALID while oBUSY: the block is dropped, the accumulator is unchanged, and oOVERRUN sets. Only iRST clears oOVERRUN.
- iACC_VALID with LAST=0 does not flush. iACC_CLEAR/iACC_LAST are ignored when iACC_VALID=0.
- Address arithmetic wraps at 2^32.
- Reset mid-flush: the flush aborts immediately, oWR_VALID drops asynchronously, and no oDONE is issued.
- Matches the ALU handshake: the ALU strobes at most every 2 cycles. accum_writeback accepts every cycle in ACCUM.

Decomposition:
- Package wb_pkg holds:
  - localparams BLOCK_WORDS=64, ROW_WORDS=8
  - typedef word_t (logic signed [31:0])
  - typedefs block_t (word_t [63:0]) and row_t (word_t [7:0])
  - enum wb_state_t {ACCUM, FLUSH}
- One natural sub-module, sat_add: a combinational WORD_W signed adder with a SATURATE parameter, instantiated 64 times via generate. The FSM, row counter and address logic stay in accum_writeback.

Test Plan:
- Single-block group:
  - Stimulus: VALID+CLEAR+LAST, all words = k (0..63), base 0x1000, iWR_READY=1.
  - Response: 8 beats, addresses 0x1000, 0x1020, …, 0x10E0; beat r words = 8r..8r+7; oDONE 9 cycles after the strobe.
- Accumulation:
  - Stimulus: CLEAR with all words 5, then VALID with all 3, then VALID+LAST with all -2.
  - Response: every flushed word = 6.
- Saturation:
  - Stimulus: CLEAR 0x7FFFFFF0, then add 0x20 with LAST.
  - Response: words = 0x7FFFFFFF. With SATURATE=0, words = 0x80000010. The negative case 0x80000001 + 0xFFFFFFF0 must give 0x80000000.
- Backpressure:
  - Stimulus: hold iWR_READY low 3 cycles on beat 2 and toggle it randomly thereafter.
  - Response: oWR_ADDR/oWR_DATA stable while stalled; exactly 8 accepted beats in order; one oDONE.
- Overrun:
  - Stimulus: strobe VALID during FLUSH.
  - Response: oOVERRUN=1; flushed data unchanged; a later group still works with oOVERRUN still 1.
- Reset mid-flush:
  - Stimulus: assert iRST during beat 4.
  - Response: oWR_VALID/oBUSY go to 0 without waiting for a clock; no oDONE; after release a new CLEAR+LAST group flushes correctly from row 0.
